dap_seq_arbiter: RTL and testbench

DAP_SEQ_ARBITER -- requirements
Module: dap_seq_arbiter

---
 rtl/dap_seq_arbiter.sv | 133 +++++++++++++
 tb/tb_dap_seq_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dap_seq_arbiter.sv
// dap_seq_arbiter: round-robin ownership of a shared sequence engine.
// One worker at a time owns the engine; its commands are forwarded with a
// registered stage, and results are routed back to the owner until every
// in-flight command has been answered.
module dap_seq_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  input  logic [NREQ-1:0]      req_tx_valid,
  input  logic [NREQ*16-1:0]   req_tx_cmd,
  input  logic [NREQ*64-1:0]   req_tx_data,
  output logic [NREQ-1:0]      req_tx_ready,
  output logic [NREQ-1:0]      req_rx_valid,
  output logic [2:0]           req_rx_flag,
  output logic [63:0]          req_rx_data,
  output logic                 seq_tx_valid,
  output logic [15:0]          seq_tx_cmd,
  output logic [63:0]          seq_tx_data,
  input  logic                 seq_tx_full,
  input  logic                 seq_rx_valid,
  input  logic [2:0]           seq_rx_flag,
  input  logic [63:0]          seq_rx_data,
  output logic                 busy,
  output logic                 err_rx
);

  localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]      MAX_OUT_C = 4'(MAX_OUT);
  localparam logic [IW-1:0]   LAST_RST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, last_owner, winner;
  logic [3:0]    outstanding, outstanding_nxt;
  logic          can_accept, accept, rx_ok;

  // Only the owner may push, and only while serving with engine headroom.
  assign can_accept   = (state == GRANT) && !seq_tx_full && (outstanding < MAX_OUT_C);
  assign req_tx_ready = grant & req & {NREQ{can_accept}};
  assign accept       = |(req_tx_valid & req_tx_ready);

  // Results with nothing outstanding are spurious and never reach a worker.
  assign rx_ok        = seq_rx_valid && (outstanding != 4'd0);
  assign req_rx_valid = grant & {NREQ{rx_ok}};
  assign req_rx_flag  = seq_rx_flag;
  assign req_rx_data  = seq_rx_data;

  assign busy = (state != IDLE);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    winner = last_owner;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NREQ]) winner = IW'((int'(last_owner) + k) % NREQ);
    end
  end

  // In-flight count after this cycle's accept and result.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, rx_ok})
      2'b10:   outstanding_nxt = outstanding + 4'd1;
      2'b01:   outstanding_nxt = outstanding - 4'd1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Next-state logic; DRAIN never returns to GRANT, the owner re-arbitrates.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (!req[owner]) state_nxt = (outstanding_nxt == 4'd0) ? IDLE : DRAIN;
      DRAIN:   if (outstanding_nxt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Ownership: grant on leaving IDLE, release and remember owner on returning.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= '0;
      owner      <= '0;
      last_owner <= LAST_RST;
    end else if (state == IDLE && state_nxt == GRANT) begin
      grant <= NREQ'(1) << winner;
      owner <= winner;
    end else if (state != IDLE && state_nxt == IDLE) begin
      grant      <= '0;
      last_owner <= owner;
    end
  end

  // In-flight counter and spurious-result flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= 4'd0;
      err_rx      <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      err_rx      <= seq_rx_valid && (outstanding == 4'd0);
    end
  end

  // Registered command stage toward the engine; payload holds between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_tx_valid <= 1'b0;
      seq_tx_cmd   <= 16'd0;
      seq_tx_data  <= 64'd0;
    end else begin
      seq_tx_valid <= accept;
      if (accept) begin
        seq_tx_cmd  <= req_tx_cmd[16*owner +: 16];
        seq_tx_data <= req_tx_data[64*owner +: 64];
      end
    end
  end

endmodule

// File: tb/tb_dap_seq_arbiter.sv
// Testbench for dap_seq_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of ownership and in-flight accounting.
module tb_dap_seq_arbiter;

  localparam int NREQ    = 4;
  localparam int MAX_OUT = 15;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NREQ-1:0]      req, grant, req_tx_valid, req_tx_ready, req_rx_valid;
  logic [NREQ*16-1:0]   req_tx_cmd;
  logic [NREQ*64-1:0]   req_tx_data;
  logic [2:0]           req_rx_flag, seq_rx_flag;
  logic [63:0]          req_rx_data, seq_rx_data, seq_tx_data;
  logic [15:0]          seq_tx_cmd;
  logic                 seq_tx_valid, seq_tx_full, seq_rx_valid, busy, err_rx;

  int checks   = 0;
  int failures = 0;

  dap_seq_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .grant(grant),
    .req_tx_valid(req_tx_valid), .req_tx_cmd(req_tx_cmd), .req_tx_data(req_tx_data),
    .req_tx_ready(req_tx_ready), .req_rx_valid(req_rx_valid), .req_rx_flag(req_rx_flag),
    .req_rx_data(req_rx_data), .seq_tx_valid(seq_tx_valid), .seq_tx_cmd(seq_tx_cmd),
    .seq_tx_data(seq_tx_data), .seq_tx_full(seq_tx_full), .seq_rx_valid(seq_rx_valid),
    .seq_rx_flag(seq_rx_flag), .seq_rx_data(seq_rx_data), .busy(busy), .err_rx(err_rx)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), serving/draining flags,
  // in-flight count, last owner, and the expected registered outputs.
  int          m_owner, m_last, m_out;
  bit          m_draining;
  logic        m_txv, m_err;
  logic [15:0] m_txcmd;
  logic [63:0] m_txdata;
  logic [NREQ-1:0] e_grant, e_ready, e_rxv;

  function automatic void model_reset();
    m_owner = -1; m_last = NREQ - 1; m_out = 0; m_draining = 1'b0;
    m_txv = 1'b0; m_err = 1'b0; m_txcmd = '0; m_txdata = '0;
  endfunction

  function automatic void model_comb();
    e_grant = '0; e_ready = '0; e_rxv = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_ready[m_owner] = !m_draining && req[m_owner] && !seq_tx_full && (m_out < MAX_OUT);
      e_rxv[m_owner]   = seq_rx_valid && (m_out > 0);
    end
  endfunction

  // Advance model by one clock using the inputs present now, then clock the DUT.
  task automatic tick();
    int  nout;
    bit  acc, rx_ok, picked;
    model_comb();
    acc = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_tx_valid[i] && e_ready[i]) begin
        acc = 1'b1;
        m_txcmd  = req_tx_cmd[16*i +: 16];
        m_txdata = req_tx_data[64*i +: 64];
      end
    end
    rx_ok = seq_rx_valid && (m_out > 0);
    nout  = m_out + (acc ? 1 : 0) - (rx_ok ? 1 : 0);
    m_err = seq_rx_valid && (m_out == 0);
    m_txv = acc;
    if (m_owner < 0) begin
      picked = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!picked && req[(m_last + k) % NREQ]) begin
          picked = 1'b1; m_owner = (m_last + k) % NREQ; m_draining = 1'b0;
        end
      end
    end else if ((m_draining || !req[m_owner]) && nout == 0) begin
      m_last = m_owner; m_owner = -1; m_draining = 1'b0;
    end else if (!req[m_owner]) begin
      m_draining = 1'b1;
    end
    m_out = nout;
    @(posedge clk);
    #1;
    model_comb();
  endtask

  task automatic clear_inputs();
    req = '0; req_tx_valid = '0; req_tx_cmd = '0; req_tx_data = '0;
    seq_tx_full = 1'b0; seq_rx_valid = 1'b0; seq_rx_flag = '0; seq_rx_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (seq_tx_valid !== 1'b0 || seq_tx_cmd !== 16'd0 || seq_tx_data !== 64'd0) begin
      failures++; $display("FAIL reset_seq_tx got=%b/%h/%h exp=0/0/0", seq_tx_valid, seq_tx_cmd, seq_tx_data);
    end
    checks++; if (err_rx !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_rx); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    req = 4'b0110;
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rr_first got=%b exp=0010", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy got=%b exp=1", busy); end
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL rr_release got=%b/%b exp=0000/0", grant, busy);
    end
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rr_second got=%b exp=0100", grant); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_commands();
    logic [15:0] cmd;
    logic [63:0] dat;
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL cmd_grant got=%b exp=0001", grant); end
    for (int k = 0; k < 3; k++) begin
      cmd = 16'($urandom); dat = {$urandom, $urandom};
      req_tx_cmd[15:0] = cmd; req_tx_data[63:0] = dat; req_tx_valid = 4'b0001;
      #1;
      checks++; if (req_tx_ready !== 4'b0001) begin failures++; $display("FAIL cmd_ready%0d got=%b exp=0001", k, req_tx_ready); end
      tick();
      checks++; if (seq_tx_valid !== 1'b1 || seq_tx_cmd !== cmd || seq_tx_data !== dat) begin
        failures++; $display("FAIL cmd_fwd%0d got=%b/%h/%h exp=1/%h/%h", k, seq_tx_valid, seq_tx_cmd, seq_tx_data, cmd, dat);
      end
    end
    req_tx_valid = '0;
    tick();
    checks++; if (seq_tx_valid !== 1'b0) begin failures++; $display("FAIL cmd_single_pulse got=%b exp=0", seq_tx_valid); end
    checks++; if (dut.outstanding !== 4'd3) begin failures++; $display("FAIL cmd_outstanding got=%0d exp=3", dut.outstanding); end
  endtask

  task automatic test_full();
    seq_tx_full = 1'b1; req_tx_valid = 4'b0001;
    #1;
    checks++; if (req_tx_ready !== 4'b0000) begin failures++; $display("FAIL full_ready got=%b exp=0000", req_tx_ready); end
    tick();
    checks++; if (seq_tx_valid !== 1'b0) begin failures++; $display("FAIL full_no_tx got=%b exp=0", seq_tx_valid); end
    seq_tx_full = 1'b0;
    #1;
    checks++; if (req_tx_ready !== 4'b0001) begin failures++; $display("FAIL unfull_ready got=%b exp=0001", req_tx_ready); end
    tick();
    checks++; if (seq_tx_valid !== 1'b1) begin failures++; $display("FAIL unfull_tx got=%b exp=1", seq_tx_valid); end
    req_tx_valid = '0;
  endtask

  task automatic test_drain();
    // Four in flight: retire two while still serving.
    for (int k = 0; k < 2; k++) begin
      seq_rx_valid = 1'b1; seq_rx_flag = 3'(k + 5); seq_rx_data = {$urandom, $urandom};
      #1;
      checks++; if (req_rx_valid !== 4'b0001 || req_rx_flag !== seq_rx_flag || req_rx_data !== seq_rx_data) begin
        failures++; $display("FAIL serve_rx%0d got=%b/%h/%h exp=0001/%h/%h", k, req_rx_valid, req_rx_flag, req_rx_data, seq_rx_flag, seq_rx_data);
      end
      tick();
    end
    seq_rx_valid = 1'b0; req = 4'b0000;
    tick();
    checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin
      failures++; $display("FAIL drain_hold got=%b/%b exp=1/0001", busy, grant);
    end
    req = 4'b0001;
    #1;
    checks++; if (req_tx_ready !== 4'b0000) begin failures++; $display("FAIL drain_no_accept got=%b exp=0000", req_tx_ready); end
    req = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      seq_rx_valid = 1'b1;
      #1;
      checks++; if (req_rx_valid !== 4'b0001) begin failures++; $display("FAIL drain_rx%0d got=%b exp=0001", k, req_rx_valid); end
      tick();
    end
    seq_rx_valid = 1'b0;
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin
      failures++; $display("FAIL drain_idle got=%b/%b exp=0/0000", busy, grant);
    end
  endtask

  task automatic test_same_cycle_and_max();
    req = 4'b0001;
    tick();
    req_tx_valid = 4'b0001;
    tick();
    seq_rx_valid = 1'b1;
    #1;
    checks++; if (req_rx_valid !== 4'b0001) begin failures++; $display("FAIL same_rx got=%b exp=0001", req_rx_valid); end
    tick();
    seq_rx_valid = 1'b0;
    checks++; if (dut.outstanding !== 4'd1) begin failures++; $display("FAIL same_cycle_count got=%0d exp=1", dut.outstanding); end
    repeat (MAX_OUT - 1) tick();
    checks++; if (req_tx_ready !== 4'b0000) begin failures++; $display("FAIL max_ready got=%b exp=0000", req_tx_ready); end
    tick();
    checks++; if (seq_tx_valid !== 1'b0) begin failures++; $display("FAIL max_no_tx got=%b exp=0", seq_tx_valid); end
    req_tx_valid = '0; req = '0; seq_rx_valid = 1'b1;
    repeat (MAX_OUT) tick();
    seq_rx_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL max_drained got=%b exp=0", busy); end
  endtask

  task automatic test_rx_idle();
    seq_rx_valid = 1'b1;
    #1;
    checks++; if (req_rx_valid !== 4'b0000) begin failures++; $display("FAIL idle_rx got=%b exp=0000", req_rx_valid); end
    tick();
    seq_rx_valid = 1'b0;
    checks++; if (err_rx !== 1'b1) begin failures++; $display("FAIL idle_err_pulse got=%b exp=1", err_rx); end
    tick();
    checks++; if (err_rx !== 1'b0) begin failures++; $display("FAIL idle_err_clear got=%b exp=0", err_rx); end
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    req_tx_valid = 4'b0010;
    repeat (2) tick();
    req_tx_valid = '0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_async got=%b/%b exp=0000/0", grant, busy);
    end
    model_reset();
    req = '0;
    @(posedge clk);
    #1 resetn = 1'b1;
    seq_rx_valid = 1'b1;
    #1;
    checks++; if (req_rx_valid !== 4'b0000) begin failures++; $display("FAIL midreset_rx got=%b exp=0000", req_rx_valid); end
    tick();
    seq_rx_valid = 1'b0;
    checks++; if (err_rx !== 1'b1) begin failures++; $display("FAIL midreset_err got=%b exp=1", err_rx); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(9) == 0) req[i] = ~req[i];
        req_tx_cmd[16*i +: 16]  = 16'($urandom);
        req_tx_data[64*i +: 64] = {$urandom, $urandom};
      end
      req_tx_valid = 4'($urandom);
      seq_tx_full  = ($urandom_range(3) == 0);
      seq_rx_valid = ($urandom_range(2) == 0);
      seq_rx_flag  = 3'($urandom);
      seq_rx_data  = {$urandom, $urandom};
      #1;
      model_comb();
      checks++;
      if (grant !== e_grant || busy !== (m_owner >= 0) || req_tx_ready !== e_ready || req_rx_valid !== e_rxv) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d got g=%b b=%b rdy=%b rxv=%b exp g=%b b=%b rdy=%b rxv=%b",
                 c, grant, busy, req_tx_ready, req_rx_valid, e_grant, (m_owner >= 0), e_ready, e_rxv);
      end
      checks++;
      if (seq_tx_valid !== m_txv || seq_tx_cmd !== m_txcmd || seq_tx_data !== m_txdata || err_rx !== m_err) begin
        failures++;
        $display("FAIL rnd_regs cyc=%0d got v=%b c=%h d=%h e=%b exp v=%b c=%h d=%h e=%b",
                 c, seq_tx_valid, seq_tx_cmd, seq_tx_data, err_rx, m_txv, m_txcmd, m_txdata, m_err);
      end
      checks++;
      if (req_rx_flag !== seq_rx_flag || req_rx_data !== seq_rx_data) begin
        failures++;
        $display("FAIL rnd_pass cyc=%0d got %h/%h exp %h/%h", c, req_rx_flag, req_rx_data, seq_rx_flag, seq_rx_data);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_commands();
    test_full();
    test_drain();
    test_same_cycle_and_max();
    test_rx_idle();
    test_reset_mid();
    clear_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
